// File: rtl/mem_loader.sv
// Program-load engine: assembles big-endian 16-bit words from a byte stream and writes them
// to consecutive addresses of a 256 x 16 memory. Define LOADER_VERIFY_EN for write-then-read-back checking.
module mem_loader (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  base_addr_i,
  input  logic [8:0]  count_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_addr_o,
  output logic [15:0] mem_wd_o,
  input  logic [15:0] mem_rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_VERIFY, S_FIN} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_FIN} state_e;
`endif

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;    // next address to write
  logic [8:0]  rem_q, rem_d;      // words still to load, 0..256
  logic [7:0]  hi_q, hi_d;
  logic [15:0] wd_q, wd_d;
  logic [7:0]  maddr_q, maddr_d;  // last address presented to memory
  logic        clr_err;
  logic        advance;

  // NOTE: every comb output gets a default first, so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    wd_d    = wd_q;
    maddr_d = maddr_q;
    clr_err = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = count_i;
          clr_err = 1'b1;
          state_d = (count_i != 9'd0) ? S_HI : S_FIN;
        end
      end
      S_HI: begin
        if (in_valid_i) begin
          hi_d    = in_data_i;
          state_d = S_LO;
        end
      end
      S_LO: begin
        // Data and address are staged here so they stay stable outside WRITE.
        if (in_valid_i) begin
          wd_d    = {hi_q, in_data_i};
          maddr_d = addr_q;
          state_d = S_WRITE;
        end
      end
`ifdef LOADER_VERIFY_EN
      S_WRITE:  state_d = S_VERIFY;
      S_VERIFY: advance = 1'b1;
`else
      S_WRITE:  advance = 1'b1;
`endif
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (advance) begin
      addr_d  = addr_q + 8'd1;
      rem_d   = rem_q - 9'd1;
      state_d = (rem_q == 9'd1) ? S_FIN : S_HI;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= 8'h00;
      rem_q   <= 9'd0;
      hi_q    <= 8'h00;
      wd_q    <= 16'h0000;
      maddr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      wd_q    <= wd_d;
      maddr_q <= maddr_d;
    end
  end

`ifdef LOADER_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (clr_err) begin
      err_q <= 1'b0;
    end else if (state_q == S_VERIFY && mem_rd_i != wd_q) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_verify;
  assign unused_verify = ^{mem_rd_i, clr_err};
  assign err_o         = 1'b0;
`endif

  assign in_ready_o = (state_q == S_HI) || (state_q == S_LO);
  assign mem_we_o   = (state_q == S_WRITE);
  assign mem_addr_o = maddr_q;
  assign mem_wd_o   = wd_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_FIN);

endmodule

// File: tb/tb_mem_loader.sv
// Randomized self-checking bench for mem_loader against a word-level load model.
module tb_mem_loader;

`ifdef LOADER_VERIFY_EN
  localparam int PER_WORD = 4;
`else
  localparam int PER_WORD = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [8:0]  count = 9'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wd, mem_rd;

  logic [15:0] tb_mem [256];
  logic [15:0] wq [$];
  bit          force_bad = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          ready_cnt = 0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .base_addr_i (base_addr),
    .count_i     (count),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wd_o    (mem_wd),
    .mem_rd_i    (mem_rd),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  assign mem_rd = (force_bad && mem_addr == 8'h20) ? 16'hDEAD : tb_mem[mem_addr];

  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wd;

  always @(negedge clk) begin
    if (mem_we)   wr_cnt++;
    if (done)     done_cnt++;
    if (in_ready) ready_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int cnt);
    wq.delete();
    for (int i = 0; i < cnt; i++) wq.push_back(16'($urandom));
  endtask

  // Runs one load of the words in wq; p_valid is the percent chance in_valid is offered each cycle.
  task automatic do_load(input logic [7:0] base, input int p_valid, input bit extra_start,
                         input bit exp_err);
    logic [7:0] bytes [$];
    int cnt, idx, cyc, lat;
    bit got_done;
    cnt = wq.size();
    foreach (wq[i]) begin
      bytes.push_back(wq[i][15:8]);
      bytes.push_back(wq[i][7:0]);
    end
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'hF00F;
    wr_cnt = 0; done_cnt = 0; ready_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = 9'(cnt);
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'($urandom); count = 9'($urandom);
    idx = 0; cyc = 0; got_done = 1'b0; lat = 0;
    while (!got_done && cyc < 5000) begin
      in_valid = (idx < bytes.size()) && ($urandom_range(0, 99) < p_valid);
      in_data  = in_valid ? bytes[idx] : 8'($urandom);
      if (extra_start && cyc == 2) begin
        start = 1'b1; base_addr = 8'h80; count = 9'd5;
      end
      @(negedge clk);
      if (cyc == 0) begin
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
      end
      if (in_valid && in_ready) idx++;
      if (done) begin
        got_done = 1'b1;
        lat = cyc + 1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    check("done_seen", got_done, 1);
    check("bytes_consumed", idx, bytes.size());
    if (p_valid == 100) begin
      if (cnt == 0) check("zero_done_within_2", lat <= 2, 1);
      else          check("done_latency", lat, PER_WORD * cnt + 1);
      check("ready_cycles", ready_cnt, 2 * cnt);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_once", done_cnt, 1);
    check("write_count", wr_cnt, cnt);
    check("busy_idle", busy, 0);
    check("in_ready_idle", in_ready, 0);
    check("err_after_load", err, exp_err);
    for (int i = 0; i < cnt; i++) check("mem_word", tb_mem[8'(base + 8'(i))], wq[i]);
    if (cnt > 0) begin
      check("last_mem_addr", mem_addr, 8'(base + 8'(cnt - 1)));
      check("last_mem_wd", mem_wd, wq[cnt - 1]);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wd", mem_wd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    wq = '{16'h1234, 16'hABCD};
    do_load(8'h10, 100, 1'b0, 1'b0);

    wq = '{16'h0001, 16'h0002};
    do_load(8'hFF, 100, 1'b0, 1'b0);

    wq.delete();
    do_load(8'h42, 100, 1'b0, 1'b0);

    fill_random(3);
    do_load(8'h60, 100, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random(4);
      do_load(8'($urandom), 40, 1'b0, 1'b0);
    end

    fill_random(256);
    do_load(8'hC3, 100, 1'b0, 1'b0);

    // Reset during LO: the half-built word must never reach memory.
    wr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h30; count = 9'd2;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_lo_ready", in_ready, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wd", mem_wd, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midrst_no_write", wr_cnt, 0);
    check("idle_ignores_bytes", in_ready, 0);
    in_valid = 1'b0;

`ifdef LOADER_VERIFY_EN
    force_bad = 1'b1;
    wq = '{16'h0001};
    do_load(8'h20, 100, 1'b0, 1'b1);
    force_bad = 1'b0;
    fill_random(1);
    do_load(8'h40, 100, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
